// File: rtl/cei_mochila_pkg.sv
// Subsystem-level defaults: number of safe-CPU masters sharing the
// peripheral port and the matching master-index type.
package cei_mochila_pkg;

    localparam int NUM_MASTERS_DEFAULT = 3;
    localparam int MASTER_IDX_W        = $clog2(NUM_MASTERS_DEFAULT);

    typedef logic [MASTER_IDX_W-1:0] master_idx_t;

endpackage

// File: rtl/obi_pkg.sv
// OBI bus request/response structures shared by masters, the arbiter
// and the peripheral subsystem slave port.
package obi_pkg;

    localparam int OBI_ADDR_W = 32;
    localparam int OBI_DATA_W = 32;
    localparam int OBI_BE_W   = OBI_DATA_W / 8;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [OBI_BE_W-1:0]   be;
        logic [OBI_ADDR_W-1:0] addr;
        logic [OBI_DATA_W-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic                  gnt;
        logic                  rvalid;
        logic [OBI_DATA_W-1:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// Small in-order FIFO holding the master index of every granted request
// until its response returns. Any DEPTH >= 1 is supported.
module obi_arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is only read after a push has written it.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/obi_periph_arbiter.sv
// Round-robin arbiter sharing the peripheral OBI slave port between masters,
// with in-order response routing. Define CRIT_SECTION_LOCK_EN for critical-section grant restriction.
module obi_periph_arbiter
    import obi_pkg::*, cei_mochila_pkg::*;
#(
    parameter int NUM_MASTERS     = NUM_MASTERS_DEFAULT,
    parameter int MAX_OUTSTANDING = 2,
    parameter int IDX_W           = $clog2(NUM_MASTERS)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  obi_req_t   master_req_i  [NUM_MASTERS],
    output obi_resp_t  master_resp_o [NUM_MASTERS],
    output obi_req_t   slave_req_o,
    input  obi_resp_t  slave_resp_i,
    input  logic       critical_section_i,
    input  logic [2:0] master_core_i,
    output logic       err_o
);

    logic [IDX_W-1:0]       rr_ptr;
    logic                   lock_valid;
    logic [IDX_W-1:0]       lock_idx;
    logic [NUM_MASTERS-1:0] eligible;
    logic [IDX_W-1:0]       rr_sel;
    logic                   rr_found;
    logic [IDX_W-1:0]       sel;
    logic                   req_valid;
    logic                   handshake;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [IDX_W-1:0]       fifo_head;
    logic                   err;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    // A full ID FIFO blocks every request, independent of a same-cycle rvalid.
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
`ifdef CRIT_SECTION_LOCK_EN
            eligible[i] = master_req_i[i].req && !fifo_full &&
                          (!critical_section_i || (int'(master_core_i) == i));
`else
            eligible[i] = master_req_i[i].req && !fifo_full;
`endif
        end
    end

`ifndef CRIT_SECTION_LOCK_EN
    logic unused_crit;
    assign unused_crit = critical_section_i ^ (^master_core_i);
`endif

    // NOTE: combinational outputs get a default first so no path infers a latch.
    always_comb begin
        rr_sel   = rr_ptr;
        rr_found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_MASTERS;
            if (!rr_found && eligible[idx]) begin
                rr_found = 1'b1;
                rr_sel   = IDX_W'(idx);
            end
        end
    end

    // A stalled request keeps its selection until granted, even across critical sections.
    always_comb begin
        if (lock_valid) begin
            sel       = lock_idx;
            req_valid = master_req_i[lock_idx].req && !fifo_full;
        end else begin
            sel       = rr_sel;
            req_valid = rr_found;
        end
    end

    assign handshake = req_valid && slave_resp_i.gnt;
    assign fifo_pop  = slave_resp_i.rvalid && !fifo_empty;

    always_comb begin
        slave_req_o     = master_req_i[sel];
        slave_req_o.req = req_valid;
    end

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            master_resp_o[i].gnt    = handshake && (sel == IDX_W'(i));
            master_resp_o[i].rvalid = fifo_pop && (fifo_head == IDX_W'(i));
            master_resp_o[i].rdata  = slave_resp_i.rdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_idx   <= '0;
        end else if (handshake) begin
            rr_ptr     <= idx_inc(sel);
            lock_valid <= 1'b0;
        end else if (req_valid) begin
            lock_valid <= 1'b1;
            lock_idx   <= sel;
        end
    end

    // A response with nothing outstanding is a slave protocol violation; flag it until reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err <= 1'b0;
        end else if (slave_resp_i.rvalid && fifo_empty) begin
            err <= 1'b1;
        end
    end

    assign err_o = err;

    obi_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (handshake),
        .pop   (fifo_pop),
        .wdata (sel),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_obi_periph_arbiter.sv
// Scoreboard bench for obi_periph_arbiter: directed scenarios plus randomized traffic against
// a queue-based reference model; model honours CRIT_SECTION_LOCK_EN when defined.
module tb_obi_periph_arbiter;
    import obi_pkg::*;

    localparam int N       = 3;
    localparam int MAX_OUT = 2;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    obi_req_t   master_req  [N];
    obi_resp_t  master_resp [N];
    obi_req_t   slave_req;
    obi_resp_t  slave_resp;
    logic       critical_section;
    logic [2:0] master_core;
    logic       err;

    always #5 clk_i = ~clk_i;

    obi_periph_arbiter #(
        .NUM_MASTERS     (N),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .master_req_i       (master_req),
        .master_resp_o      (master_resp),
        .slave_req_o        (slave_req),
        .slave_resp_i       (slave_resp),
        .critical_section_i (critical_section),
        .master_core_i      (master_core),
        .err_o              (err)
    );

    typedef struct {
        int          m;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    int model_rr;
    bit stall_valid;
    int stall_idx;
    bit model_err;
    bit hs;
    bit any_req;
    int hs_m;
    bit err_pending;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit crit_ok(input int i);
`ifdef CRIT_SECTION_LOCK_EN
        return !critical_section || (int'(master_core) == i);
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit pending_reqs();
        bit any = 1'b0;
        for (int i = 0; i < N; i++) any |= master_req[i].req;
        return any;
    endfunction

    task automatic raise(input int i, input logic [31:0] addr);
        master_req[i].req   = 1'b1;
        master_req[i].we    = 1'($urandom_range(1));
        master_req[i].be    = 4'($urandom_range(15));
        master_req[i].addr  = addr;
        master_req[i].wdata = $urandom;
    endtask

    task automatic set_slave(input bit gnt, input bit rv);
        slave_resp.gnt    = gnt;
        slave_resp.rvalid = rv;
        slave_resp.rdata  = (exp_q.size() > 0) ? exp_q[0].rdata : $urandom;
    endtask

    // Expected address phase: an ungranted presented request stays presented; otherwise the
    // first requester at or after the pointer wins, and nothing is offered with MAX_OUT outstanding.
    task automatic check_cycle();
        int             cnt;
        bit             full;
        int             sel;
        logic [N-1:0]   exp_gnt;
        logic [N-1:0]   act_gnt;
        cnt     = exp_q.size();
        full    = (cnt >= MAX_OUT);
        sel     = -1;
        exp_gnt = '0;
        if (stall_valid) begin
            if (master_req[stall_idx].req && !full) sel = stall_idx;
        end else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (model_rr + k) % N;
                if (sel < 0 && master_req[i].req && !full && crit_ok(i)) sel = i;
            end
        end
        any_req = (sel >= 0);
        hs      = any_req && slave_resp.gnt;
        hs_m    = sel;
        check("slave_req.req", 64'(slave_req.req), 64'(any_req));
        if (any_req) begin
            check("slave_req.addr", 64'(slave_req.addr), 64'(master_req[sel].addr));
            check("slave_req.wdata", 64'(slave_req.wdata), 64'(master_req[sel].wdata));
            check("slave_req.we_be", 64'({slave_req.we, slave_req.be}),
                  64'({master_req[sel].we, master_req[sel].be}));
        end
        if (hs) exp_gnt[sel] = 1'b1;
        for (int i = 0; i < N; i++) act_gnt[i] = master_resp[i].gnt;
        check("gnt", 64'(act_gnt), 64'(exp_gnt));
        check("err_o", 64'(err), 64'(model_err));
        err_pending = slave_resp.rvalid && (cnt == 0);
    endtask

    task automatic update_model();
        if (hs) begin
            exp_q.push_back('{hs_m, $urandom});
            model_rr              = (hs_m + 1) % N;
            stall_valid           = 1'b0;
            master_req[hs_m].req  = 1'b0;
        end else if (any_req) begin
            stall_valid = 1'b1;
            stall_idx   = hs_m;
        end
        if (err_pending) model_err = 1'b1;
    endtask

    // Inputs are driven at posedge+1, outputs checked at posedge+4, responses at negedge.
    task automatic cycle();
        #3;
        check_cycle();
        @(posedge clk_i);
        #1;
        update_model();
    endtask

    task automatic drain();
        critical_section = 1'b0;
        for (int c = 0; c < 50 && (exp_q.size() > 0 || pending_reqs()); c++) begin
            set_slave(1'b1, exp_q.size() > 0);
            cycle();
        end
        check("drain_outstanding", 64'(exp_q.size()), 64'(0));
        set_slave(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) master_req[i] = '0;
        slave_resp = '0;
        #1 rst_i = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            check("reset_gnt", 64'(master_resp[i].gnt), 64'(0));
            check("reset_rvalid", 64'(master_resp[i].rvalid), 64'(0));
        end
        check("reset_err", 64'(err), 64'(0));
        check("reset_req", 64'(slave_req.req), 64'(0));
        exp_q.delete();
        model_rr    = 0;
        stall_valid = 1'b0;
        model_err   = 1'b0;
        hs          = 1'b0;
        any_req     = 1'b0;
        err_pending = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    // Response monitor: the head of the scoreboard queue must receive the next rvalid.
    initial begin
        logic [N-1:0] exp_rv;
        logic [N-1:0] act_rv;
        exp_t         e;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                exp_rv = '0;
                if (slave_resp.rvalid && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    exp_rv[e.m] = 1'b1;
                    check("rdata", 64'(master_resp[e.m].rdata), 64'(e.rdata));
                end
                for (int i = 0; i < N; i++) act_rv[i] = master_resp[i].rvalid;
                check("rvalid", 64'(act_rv), 64'(exp_rv));
            end
        end
    end

    int p_req [4] = '{50, 70, 90, 30};
    int p_gnt [4] = '{100, 40, 80, 60};
    int p_rv  [4] = '{100, 60, 15, 50};
    int p_crit[4] = '{0, 30, 50, 80};

    initial begin
        critical_section = 1'b0;
        master_core      = 3'd0;
        do_reset();

        // Single master, immediate grant, response next cycle.
        raise(0, 32'h10);
        set_slave(1'b1, 1'b0);
        cycle();
        set_slave(1'b0, 1'b1);
        cycle();
        drain();

        // Continuous requests from all masters with grant always high.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++)
                if (!master_req[i].req) raise(i, 32'h100 + 32'(i * 16 + c * 4));
            set_slave(1'b1, exp_q.size() > 0);
            cycle();
        end
        drain();

        // Stalled m1 keeps the address phase while m0 joins.
        raise(1, 32'h200);
        set_slave(1'b0, 1'b0);
        cycle();
        raise(0, 32'h300);
        cycle();
        cycle();
        set_slave(1'b1, 1'b0);
        cycle();
        set_slave(1'b1, 1'b0);
        cycle();
        drain();

        // Outstanding limit: third request waits until a response frees a slot.
        for (int i = 0; i < N; i++) raise(i, 32'h400 + 32'(i * 4));
        for (int c = 0; c < 3; c++) begin
            set_slave(1'b1, 1'b0);
            cycle();
        end
        set_slave(1'b1, 1'b1);
        cycle();
        set_slave(1'b1, 1'b0);
        cycle();
        drain();

        // Spurious response sets a sticky error; reset mid-burst clears everything.
        set_slave(1'b0, 1'b1);
        cycle();
        set_slave(1'b0, 1'b0);
        cycle();
        cycle();
        for (int i = 0; i < N; i++) raise(i, 32'h500 + 32'(i * 4));
        set_slave(1'b1, 1'b0);
        cycle();
        cycle();
        do_reset();

        // Critical section on core 2, then release.
        critical_section = 1'b1;
        master_core      = 3'd2;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) critical_section = 1'b0;
            for (int i = 0; i < N; i++)
                if (!master_req[i].req) raise(i, 32'h600 + 32'(i * 16 + c * 4));
            set_slave(1'b1, exp_q.size() > 0);
            cycle();
        end
        drain();

        // Randomized traffic phases.
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 500; c++) begin
                if (ph == 2 && c == 250) do_reset();
                for (int i = 0; i < N; i++)
                    if (!master_req[i].req && $urandom_range(99) < p_req[ph])
                        raise(i, $urandom & 32'hFFFF_FFFC);
                critical_section = ($urandom_range(99) < p_crit[ph]);
                master_core      = 3'($urandom_range(3));
                set_slave($urandom_range(99) < p_gnt[ph],
                          exp_q.size() > 0 && $urandom_range(99) < p_rv[ph]);
                cycle();
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
